key_event_sched: RTL and testbench
==================================

KEY_EVENT_SCHED -- requirements
Module: key_event_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port key_pls, input, 7 bits: single-cycle key press pulses from the key edge-detect stage; bit i = key i.
REQ-004 SHALL have port evt_valid, output, 1 bit: event FIFO head valid.
REQ-005 SHALL have port evt_code, output, 3 bits: key index 0..6 at the FIFO head; 0 when evt_valid=0.
REQ-006 SHALL have port evt_ready, input, 1 bit: consumer accepts the head when evt_valid=1.
REQ-007 SHALL have port pend, output, 7 bits: per-key pending flags.
REQ-008 SHALL have port fifo_cnt, output, 3 bits: FIFO occupancy, 0..4.
REQ-009 SHALL have port drop_pls, output, 1 bit: one-cycle pulse when a press is lost.
REQ-010 SHALL have port drop_cnt, output, 8 bits: saturating count of lost presses.

Function
REQ-011 SHALL set pend[i] at the clock edge ending any cycle in which key_pls[i]=1; several keys in one cycle all set.
REQ-012 SHALL treat key_pls[i]=1 while pend[i]=1 and key i not granted that cycle as a lost press: drop_pls=1 next cycle, drop_cnt+1 saturating at 255.
REQ-013 SHALL grant at most one pending key per cycle, only when pend!=0 and fifo_cnt<4 at the start of the cycle; granted code pushed to FIFO tail and pend bit cleared at that edge.
REQ-014 SHALL keep pend[i] set (no drop) if key_pls[i]=1 in the same cycle key i is granted.
REQ-015 SHALL pop the FIFO head on any edge where evt_valid=1 and evt_ready=1; evt_ready ignored when evt_valid=0.
REQ-016 SHALL allow push and pop in the same cycle; fifo_cnt unchanged; with fifo_cnt=4, the pop frees no slot for that cycle's grant (full blocks push).
REQ-017 SHALL give latency of 2 cycles with empty FIFO: pulse in cycle N, pend in N+1, grant in N+1, evt_valid=1 with code in N+2.
REQ-018 SHALL present events in grant order; evt_code stable while evt_valid=1 and evt_ready=0.
REQ-019 SHALL never let a full FIFO drop a pending key; backpressure holds it in pend.
REQ-020 SHALL implement the FIFO as 4 entries x 3 bits with 2-bit wrapping read/write pointers.

Reset
REQ-021 SHALL on rst=1 clear pend, FIFO contents, pointers, fifo_cnt, drop_cnt, drop_pls; evt_valid=0, evt_code=0; round-robin pointer set to 6.
REQ-022 SHALL give rst priority over key_pls, grant and pop in the same cycle; presses and queued events during reset are discarded.
REQ-023 SHALL resume normal capture of key_pls in the first cycle after rst deasserts.

Configuration
REQ-024 SHALL, with macro KEYQ_ROUND_ROBIN_EN defined, grant the first pending key searching upward from (last granted index + 1) mod 7; pointer updates on grant only.
REQ-025 SHALL, without KEYQ_ROUND_ROBIN_EN, grant the lowest-index pending key (key 0 highest priority); no pointer register built.

Verification
REQ-026 SHALL cover: after reset, key_pls=0000100 one cycle, evt_ready=1 -> evt_valid=1, evt_code=2 exactly 2 cycles later, one cycle only, fifo_cnt back to 0.
REQ-027 SHALL cover: key_pls=1111111 one cycle, evt_ready=0 -> fifo_cnt reaches 4 (codes 0,1,2,3 in both modes from reset), pend=1110000 held; then evt_ready=1 -> codes 0..6 in order, no drop.
REQ-028 SHALL cover: key 5 pulsed twice while FIFO full and pend[5]=1 -> drop_pls one pulse, drop_cnt=1; 300 such drops -> drop_cnt=255.
REQ-029 SHALL cover with KEYQ_ROUND_ROBIN_EN: keys 0 and 3 pending continuously, evt_ready=1 -> grants alternate 0,3,0,3; without macro -> key 0 every grant while re-pulsed.
REQ-030 SHALL cover: rst asserted one cycle with fifo_cnt=3 and pend=0000011 -> next cycle fifo_cnt=0, pend=0, evt_valid=0, drop_cnt=0.

Source files
------------

// File: rtl/key_event_sched.sv
// Key press scheduler: latches key pulses into pending flags and queues granted key codes in a 4-deep FIFO.
// Optional macro KEYQ_ROUND_ROBIN_EN selects round-robin grant; default is fixed priority (key 0 highest).
module key_event_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] key_pls,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  input  logic       evt_ready,
  output logic [6:0] pend,
  output logic [2:0] fifo_cnt,
  output logic       drop_pls,
  output logic [7:0] drop_cnt
);

  localparam int unsigned NKEYS  = 7;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DROP_W = 8;

  logic [NKEYS-1:0]  r_pend;
  logic [CODE_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_drop_pls;
  logic [DROP_W-1:0] r_drop_cnt;
  logic              r_evt_valid;
  logic [CODE_W-1:0] r_evt_code;

  logic              w_can_push;
  logic              w_grant_vld;
  logic [CODE_W-1:0] w_grant_idx;
  logic [NKEYS-1:0]  w_grant_oh;
  logic              w_push;
  logic              w_pop;
  logic [NKEYS-1:0]  w_pend_nxt;
  logic              w_drop;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [PTR_W-1:0]  w_wr_ptr_nxt;
  logic [PTR_W-1:0]  w_rd_ptr_nxt;
  logic [CODE_W-1:0] w_head_nxt;

  assign w_can_push = (r_cnt < CNT_W'(DEPTH));

`ifdef KEYQ_ROUND_ROBIN_EN
  logic [CODE_W-1:0] r_rr_ptr;
  logic [3:0]        w_rr_idx;

  // First pending key searching upward from the key after the last grant.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_rr_idx    = '0;
    for (int k = 0; k < NKEYS; k++) begin
      w_rr_idx = 4'(r_rr_ptr) + 4'd1 + 4'(k);
      if (w_rr_idx >= 4'(NKEYS)) w_rr_idx = w_rr_idx - 4'(NKEYS);
      if (!w_grant_vld && r_pend[w_rr_idx[CODE_W-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_rr_idx[CODE_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         r_rr_ptr <= CODE_W'(NKEYS - 1);
    else if (w_push) r_rr_ptr <= w_grant_idx;
  end
`else
  // Lowest-index pending key wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = CODE_W'(i);
      end
    end
  end
`endif

  // Next-state for pending flags, FIFO bookkeeping and the head that will be presented.
  always_comb begin
    w_push       = w_grant_vld & w_can_push;
    w_pop        = r_evt_valid & evt_ready;
    w_grant_oh   = w_push ? (NKEYS'(1) << w_grant_idx) : '0;
    w_pend_nxt   = (r_pend & ~w_grant_oh) | key_pls;
    w_drop       = |(key_pls & r_pend & ~w_grant_oh);
    w_cnt_nxt    = r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_push);
    w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
    w_head_nxt   = r_mem[w_rd_ptr_nxt];
    if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) w_head_nxt = w_grant_idx;
    if (w_cnt_nxt == '0) w_head_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend      <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_drop_pls  <= 1'b0;
      r_drop_cnt  <= '0;
      r_evt_valid <= 1'b0;
      r_evt_code  <= '0;
    end else begin
      r_pend      <= w_pend_nxt;
      if (w_push) r_mem[r_wr_ptr] <= w_grant_idx;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_drop_pls  <= w_drop;
      if (w_drop && (r_drop_cnt != {DROP_W{1'b1}})) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      r_evt_valid <= (w_cnt_nxt != '0);
      r_evt_code  <= w_head_nxt;
    end
  end

  assign pend      = r_pend;
  assign fifo_cnt  = r_cnt;
  assign drop_pls  = r_drop_pls;
  assign drop_cnt  = r_drop_cnt;
  assign evt_valid = r_evt_valid;
  assign evt_code  = r_evt_code;

endmodule

// File: tb/tb_key_event_sched.sv
// Directed self-checking bench for key_event_sched (works with or without KEYQ_ROUND_ROBIN_EN).
module tb_key_event_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] key_pls;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic       evt_ready;
  logic [6:0] pend;
  logic [2:0] fifo_cnt;
  logic       drop_pls;
  logic [7:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  key_event_sched dut (
    .clk      (clk),
    .rst      (rst),
    .key_pls  (key_pls),
    .evt_valid(evt_valid),
    .evt_code (evt_code),
    .evt_ready(evt_ready),
    .pend     (pend),
    .fifo_cnt (fifo_cnt),
    .drop_pls (drop_pls),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; key_pls = '0; evt_ready = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", evt_valid); end
    checks++; if (evt_code !== 3'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", evt_code); end
    checks++; if (pend !== 7'd0) begin failures++; $display("FAIL reset_pend got=%b exp=0", pend); end
    checks++; if (fifo_cnt !== 3'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", fifo_cnt); end
    checks++; if (drop_cnt !== 8'd0 || drop_pls !== 1'b0) begin failures++; $display("FAIL reset_drop got=%0d/%b exp=0/0", drop_cnt, drop_pls); end
  endtask

  task automatic test_single();
    do_reset();
    evt_ready = 1'b1;
    key_pls = 7'b0000100;
    step();
    key_pls = '0;
    checks++; if (pend !== 7'b0000100 || evt_valid !== 1'b0) begin failures++; $display("FAIL single_n1 pend=%b valid=%b exp=0000100/0", pend, evt_valid); end
    step();
    checks++; if (evt_valid !== 1'b1 || evt_code !== 3'd2) begin failures++; $display("FAIL single_n2 valid=%b code=%0d exp=1/2", evt_valid, evt_code); end
    checks++; if (pend !== 7'd0 || fifo_cnt !== 3'd1) begin failures++; $display("FAIL single_n2_state pend=%b cnt=%0d exp=0/1", pend, fifo_cnt); end
    step();
    checks++; if (evt_valid !== 1'b0 || evt_code !== 3'd0 || fifo_cnt !== 3'd0) begin failures++; $display("FAIL single_n3 valid=%b code=%0d cnt=%0d exp=0/0/0", evt_valid, evt_code, fifo_cnt); end
  endtask

  task automatic test_fill();
    int n;
    int cyc;
    do_reset();
    key_pls = 7'b1111111;
    step();
    key_pls = '0;
    for (int i = 0; i < 5; i++) step();
    checks++; if (fifo_cnt !== 3'd4 || pend !== 7'b1110000) begin failures++; $display("FAIL fill_full cnt=%0d pend=%b exp=4/1110000", fifo_cnt, pend); end
    checks++; if (evt_valid !== 1'b1 || evt_code !== 3'd0) begin failures++; $display("FAIL fill_hold valid=%b code=%0d exp=1/0", evt_valid, evt_code); end
    step();
    checks++; if (evt_code !== 3'd0 || fifo_cnt !== 3'd4) begin failures++; $display("FAIL fill_stable code=%0d cnt=%0d exp=0/4", evt_code, fifo_cnt); end
    evt_ready = 1'b1;
    n = 0; cyc = 0;
    while (n < 7 && cyc < 30) begin
      if (evt_valid) begin
        checks++; if (evt_code !== 3'(n)) begin failures++; $display("FAIL fill_order idx=%0d got=%0d exp=%0d", n, evt_code, n); end
        n++;
      end
      step(); cyc++;
    end
    checks++; if (n != 7) begin failures++; $display("FAIL fill_timeout got=%0d events exp=7", n); end
    checks++; if (fifo_cnt !== 3'd0 || drop_cnt !== 8'd0 || pend !== 7'd0) begin failures++; $display("FAIL fill_end cnt=%0d drop=%0d pend=%b exp=0/0/0", fifo_cnt, drop_cnt, pend); end
    evt_ready = 1'b0;
  endtask

  task automatic test_drop();
    do_reset();
    key_pls = 7'b0101111;
    step();
    key_pls = '0;
    for (int i = 0; i < 4; i++) step();
    checks++; if (fifo_cnt !== 3'd4 || pend !== 7'b0100000) begin failures++; $display("FAIL drop_setup cnt=%0d pend=%b exp=4/0100000", fifo_cnt, pend); end
    key_pls = 7'b0100000;
    step();
    key_pls = '0;
    checks++; if (drop_pls !== 1'b1 || drop_cnt !== 8'd1) begin failures++; $display("FAIL drop_first pls=%b cnt=%0d exp=1/1", drop_pls, drop_cnt); end
    step();
    checks++; if (drop_pls !== 1'b0 || drop_cnt !== 8'd1) begin failures++; $display("FAIL drop_one_pulse pls=%b cnt=%0d exp=0/1", drop_pls, drop_cnt); end
    key_pls = 7'b0100000;
    for (int i = 0; i < 300; i++) step();
    checks++; if (drop_pls !== 1'b1 || drop_cnt !== 8'd255) begin failures++; $display("FAIL drop_sat pls=%b cnt=%0d exp=1/255", drop_pls, drop_cnt); end
    key_pls = '0;
    step();
    checks++; if (drop_pls !== 1'b0 || drop_cnt !== 8'd255) begin failures++; $display("FAIL drop_sat_hold pls=%b cnt=%0d exp=0/255", drop_pls, drop_cnt); end
    checks++; if (fifo_cnt !== 3'd4 || pend !== 7'b0100000) begin failures++; $display("FAIL drop_backpressure cnt=%0d pend=%b exp=4/0100000", fifo_cnt, pend); end
  endtask

  task automatic test_arbitration();
    logic [2:0] exp_codes [4];
    int n;
    int cyc;
`ifdef KEYQ_ROUND_ROBIN_EN
    exp_codes[0] = 3'd0; exp_codes[1] = 3'd3; exp_codes[2] = 3'd0; exp_codes[3] = 3'd3;
`else
    exp_codes[0] = 3'd0; exp_codes[1] = 3'd0; exp_codes[2] = 3'd0; exp_codes[3] = 3'd0;
`endif
    do_reset();
    evt_ready = 1'b1;
    key_pls = 7'b0001001;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 20) begin
      if (evt_valid) begin
        checks++; if (evt_code !== exp_codes[n]) begin failures++; $display("FAIL arb_grant idx=%0d got=%0d exp=%0d", n, evt_code, exp_codes[n]); end
        n++;
      end
      step(); cyc++;
    end
    checks++; if (n != 4) begin failures++; $display("FAIL arb_timeout got=%0d events exp=4", n); end
    key_pls = '0;
    evt_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    key_pls = 7'b0011100;
    step();
    key_pls = '0;
    step(); step();
    key_pls = 7'b0000011;
    step();
    key_pls = '0;
    checks++; if (fifo_cnt !== 3'd3 || pend !== 7'b0000011) begin failures++; $display("FAIL rstmid_setup cnt=%0d pend=%b exp=3/0000011", fifo_cnt, pend); end
    rst = 1'b1; key_pls = 7'b1000000; evt_ready = 1'b1;
    step();
    rst = 1'b0; key_pls = '0; evt_ready = 1'b0;
    checks++; if (fifo_cnt !== 3'd0 || pend !== 7'd0 || evt_valid !== 1'b0 || drop_cnt !== 8'd0) begin failures++; $display("FAIL rstmid_clear cnt=%0d pend=%b valid=%b drop=%0d exp=0/0/0/0", fifo_cnt, pend, evt_valid, drop_cnt); end
    key_pls = 7'b0000010;
    step();
    key_pls = '0;
    checks++; if (pend !== 7'b0000010) begin failures++; $display("FAIL rstmid_resume pend=%b exp=0000010", pend); end
  endtask

  initial begin
    rst = 1'b1; key_pls = '0; evt_ready = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_drop();
    test_arbitration();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
